board_mgr: RTL and testbench

BOARD_MGR -- requirements
Module: board_mgr

---
 rtl/board_pkg.sv | 44 ++++
 rtl/board_line_chk.sv | 59 +++++
 rtl/board_mgr.sv | 216 +++++++++++++++++++++
 tb/tb_board_mgr.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared codes, types and helpers for the board manager
//
// Holds the cell, move_status, game_state and FSM encodings used by
// board_mgr and board_line_chk, plus two small helper functions.
package board_pkg;

  typedef enum logic [1:0] {
    CELL_BLANK = 2'd0,
    CELL_X     = 2'd1,
    CELL_O     = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    MS_OK       = 2'd0,
    MS_OCCUPIED = 2'd1,
    MS_RANGE    = 2'd2,
    MS_OVER     = 2'd3
  } move_status_t;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'd0,
    GS_X_WIN   = 2'd1,
    GS_O_WIN   = 2'd2,
    GS_DRAW    = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  // Number of lines scanned per move: all rows, all columns, and both
  // diagonals only when the board is square.
  function automatic int line_count(input int rows, input int cols);
    return rows + cols + ((rows == cols) ? 2 : 0);
  endfunction

  function automatic cell_t other_mark(input cell_t m);
    return (m == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_line_chk.sv
// rtl/board_line_chk.sv - single-line win evaluator with registered hit
//
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   board     flat board, cell (r,c) at bits [2*(r*COLS+c)+:2]
//   line_idx  line to test: rows 0..ROWS-1, then columns, then (square
//             boards only) main and anti diagonal; larger indices never hit
//   mark      mark every cell of the line must equal
//   hit       registered result for the line_idx/mark of the previous cycle
module board_line_chk
  import board_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int LW   = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [2*ROWS*COLS-1:0]   board,
  input  logic [LW-1:0]            line_idx,
  input  logic [1:0]               mark,
  output logic                     hit
);

  logic hit_d;
  int   li;

  function automatic logic [1:0] cell_at(input logic [2*ROWS*COLS-1:0] b,
                                         input int r, input int c);
    return b[2*(r*COLS+c) +: 2];
  endfunction

  always_comb begin
    hit_d = 1'b1;
    li    = int'(line_idx);
    if (li < ROWS) begin
      for (int c = 0; c < COLS; c++)
        if (cell_at(board, li, c) != mark) hit_d = 1'b0;
    end else if (li < ROWS + COLS) begin
      for (int r = 0; r < ROWS; r++)
        if (cell_at(board, r, li - ROWS) != mark) hit_d = 1'b0;
    end else if ((ROWS == COLS) && (li == ROWS + COLS)) begin
      for (int i = 0; i < ROWS; i++)
        if (cell_at(board, i, i) != mark) hit_d = 1'b0;
    end else if ((ROWS == COLS) && (li == ROWS + COLS + 1)) begin
      for (int i = 0; i < ROWS; i++)
        if (cell_at(board, i, COLS - 1 - i) != mark) hit_d = 1'b0;
    end else begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hit <= 1'b0;
    else          hit <= hit_d;
  end

endmodule

// File: rtl/board_mgr.sv
// rtl/board_mgr.sv - tic-tac-toe style board manager with move FSM and line scan
//
// Optional feature macro: BOARD_UNDO_EN (adds the undo input and the
// last-move register).
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   new_game     synchronous clear pulse, overrides everything
//   move_valid   move request; accepted when move_ready is also high
//   move_ready   high only in IDLE (and not during reset)
//   move_row     target row
//   move_col     target column
//   move_done    one-cycle pulse closing each accepted request
//   move_status  0 OK, 1 OCCUPIED, 2 RANGE, 3 OVER; valid with move_done
//   board        flat cell states, cell (r,c) at bits [2*(r*COLS+c)+:2]
//   turn         next player to move (CELL_X or CELL_O)
//   game_state   0 PLAYING, 1 X_WIN, 2 O_WIN, 3 DRAW
//   undo         (BOARD_UNDO_EN only) take back the last move
module board_mgr
  import board_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       new_game,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [$clog2(ROWS)-1:0]    move_row,
  input  logic [$clog2(COLS)-1:0]    move_col,
  output logic                       move_done,
  output logic [1:0]                 move_status,
  output logic [2*ROWS*COLS-1:0]     board,
  output logic [1:0]                 turn,
  output logic [1:0]                 game_state
`ifdef BOARD_UNDO_EN
  ,
  input  logic                       undo
`endif
);

  localparam int NCELL = ROWS * COLS;
  localparam int L     = line_count(ROWS, COLS);
  localparam int LW    = $clog2(L + 1);
  localparam int CNTW  = $clog2(NCELL + 1);

  fsm_state_t             state_q, state_d;
  logic [2*NCELL-1:0]     board_q;
  cell_t                  turn_q;
  game_state_t            game_q;
  move_status_t           status_q;
  logic [CNTW-1:0]        cnt_q;
  logic [LW-1:0]          scan_cnt_q;
  logic                   win_q;
  logic                   ready_q;

  logic                   accept;
  logic                   in_range;
  int                     cell_i;
  logic                   cell_blank;
  logic                   legal;
  move_status_t           rej_status;
  logic                   scan_last;
  logic                   win_final;
  logic [LW-1:0]          line_idx;
  logic                   line_hit;

`ifdef BOARD_UNDO_EN
  localparam int IDXW = $clog2(NCELL);
  logic [IDXW-1:0]        last_idx_q;
  logic                   last_vld_q;
  logic                   undo_req;
  assign undo_req = undo && !move_valid && !new_game && move_ready;
`endif

  // Request decode. cell_i is forced to 0 when out of range so the board
  // select never leaves the vector.
  always_comb begin
    accept     = move_valid && move_ready && !new_game;
    in_range   = (int'(move_row) < ROWS) && (int'(move_col) < COLS);
    cell_i     = in_range ? (int'(move_row) * COLS + int'(move_col)) : 0;
    cell_blank = (board_q[2*cell_i +: 2] == CELL_BLANK);
    legal      = in_range && (game_q == GS_PLAYING) && cell_blank;
    // OVER outranks OCCUPIED so a move on a finished, full board reports OVER.
    if (!in_range)                rej_status = MS_RANGE;
    else if (game_q != GS_PLAYING) rej_status = MS_OVER;
    else if (!cell_blank)         rej_status = MS_OCCUPIED;
    else                          rej_status = MS_OK;
  end

  // The checker registers its result, so line k is issued one cycle before
  // it is consumed: WRITE issues line 0 and SCAN cycle k consumes line k
  // while issuing line k+1. The final SCAN cycle therefore already holds the
  // last line's hit, letting game_state update on entry to DONE.
  assign line_idx  = (state_q == ST_SCAN) ? (scan_cnt_q + LW'(1)) : '0;
  assign scan_last = (state_q == ST_SCAN) && (int'(scan_cnt_q) == L - 1);
  assign win_final = win_q || line_hit;

  board_line_chk #(.ROWS(ROWS), .COLS(COLS), .LW(LW)) u_line_chk (
    .clock    (clock),
    .reset_n  (reset_n),
    .board    (board_q),
    .line_idx (line_idx),
    .mark     (turn_q),
    .hit      (line_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    move_ready = ready_q && (state_q == ST_IDLE);
    move_done  = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = legal ? ST_WRITE : ST_DONE;
`ifdef BOARD_UNDO_EN
        else if (undo_req) state_d = ST_DONE;
`endif
      end
      ST_WRITE: state_d = ST_SCAN;
      ST_SCAN:  if (scan_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (new_game) state_d = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board_q    <= '0;
      turn_q     <= CELL_X;
      game_q     <= GS_PLAYING;
      status_q   <= MS_OK;
      cnt_q      <= '0;
      scan_cnt_q <= '0;
      win_q      <= 1'b0;
      ready_q    <= 1'b0;
`ifdef BOARD_UNDO_EN
      last_idx_q <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
      if (new_game) begin
        board_q    <= '0;
        turn_q     <= CELL_X;
        game_q     <= GS_PLAYING;
        status_q   <= MS_OK;
        cnt_q      <= '0;
        scan_cnt_q <= '0;
        win_q      <= 1'b0;
`ifdef BOARD_UNDO_EN
        last_vld_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              if (legal) begin
                board_q[2*cell_i +: 2] <= turn_q;
                status_q   <= MS_OK;
                scan_cnt_q <= '0;
                win_q      <= 1'b0;
                if (int'(cnt_q) != NCELL) cnt_q <= cnt_q + CNTW'(1);
`ifdef BOARD_UNDO_EN
                last_idx_q <= IDXW'(cell_i);
                last_vld_q <= 1'b1;
`endif
              end else begin
                status_q <= rej_status;
              end
            end
`ifdef BOARD_UNDO_EN
            else if (undo_req) begin
              if (last_vld_q) begin
                board_q[2*int'(last_idx_q) +: 2] <= CELL_BLANK;
                turn_q     <= other_mark(turn_q);
                game_q     <= GS_PLAYING;
                status_q   <= MS_OK;
                last_vld_q <= 1'b0;
                if (cnt_q != '0) cnt_q <= cnt_q - CNTW'(1);
              end else begin
                status_q <= MS_OVER;
              end
            end
`endif
          end
          ST_SCAN: begin
            win_q      <= win_final;
            scan_cnt_q <= scan_cnt_q + LW'(1);
            if (scan_last) begin
              turn_q <= other_mark(turn_q);
              if (win_final)
                game_q <= (turn_q == CELL_X) ? GS_X_WIN : GS_O_WIN;
              else if (int'(cnt_q) == NCELL)
                game_q <= GS_DRAW;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign board       = board_q;
  assign turn        = turn_q;
  assign game_state  = game_q;
  assign move_status = status_q;

endmodule

// File: tb/tb_board_mgr.sv
// tb/tb_board_mgr.sv - directed self-checking bench for board_mgr (3x3 and 3x4)
module tb_board_mgr;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        new_game;
  logic        valid_a, valid_b;
  logic [1:0]  row, col;
  logic        rdy_a, rdy_b, done_a, done_b;
  logic [1:0]  st_a, st_b, turn_a, turn_b, game_a, game_b;
  logic [17:0] board_a;
  logic [23:0] board_b;
`ifdef BOARD_UNDO_EN
  logic        undo_a;
  logic        undo_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          r_lat, r_st, r_game, r_turn;
  logic [23:0] r_board, r_board1;

  board_mgr #(.ROWS(3), .COLS(3)) dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .new_game    (new_game),
    .move_valid  (valid_a),
    .move_ready  (rdy_a),
    .move_row    (row),
    .move_col    (col),
    .move_done   (done_a),
    .move_status (st_a),
    .board       (board_a),
    .turn        (turn_a),
    .game_state  (game_a)
`ifdef BOARD_UNDO_EN
    ,
    .undo        (undo_a)
`endif
  );

  board_mgr #(.ROWS(3), .COLS(4)) dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .new_game    (new_game),
    .move_valid  (valid_b),
    .move_ready  (rdy_b),
    .move_row    (row),
    .move_col    (col),
    .move_done   (done_b),
    .move_status (st_b),
    .board       (board_b),
    .turn        (turn_b),
    .game_state  (game_b)
`ifdef BOARD_UNDO_EN
    ,
    .undo        (undo_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic capture(input bit sel);
    r_st    = int'(sel ? st_b : st_a);
    r_game  = int'(sel ? game_b : game_a);
    r_turn  = int'(sel ? turn_b : turn_a);
    r_board = sel ? board_b : {6'b0, board_a};
  endtask

  task automatic wait_done(input bit sel);
    r_lat    = 1;
    r_board1 = sel ? board_b : {6'b0, board_a};
    while (!(sel ? done_b : done_a) && r_lat < 40) begin
      @(posedge clock); #1;
      r_lat++;
    end
    if (!(sel ? done_b : done_a)) check("done_timeout", 32'd0, 32'd1);
    capture(sel);
  endtask

  task automatic wait_ready(input bit sel);
    int n;
    n = 0;
    @(negedge clock);
    while (!(sel ? rdy_b : rdy_a) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one move request and wait for its move_done; r_lat counts cycles
  // from the accepting edge (1 = the cycle right after acceptance).
  task automatic play(input bit sel, input int r, input int c);
    wait_ready(sel);
    row = 2'(r);
    col = 2'(c);
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clock); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    wait_done(sel);
  endtask

`ifdef BOARD_UNDO_EN
  task automatic do_undo();
    wait_ready(1'b0);
    undo_a = 1'b1;
    @(posedge clock); #1;
    undo_a = 1'b0;
    wait_done(1'b0);
  endtask
`endif

  task automatic pulse_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
  endtask

  int dr_draw[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int dc_draw[9] = '{0, 2, 1, 0, 2, 1, 0, 1, 2};
  int dr_owin[6] = '{0, 0, 0, 1, 1, 2};
  int dc_owin[6] = '{0, 2, 1, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    new_game = 1'b0;
    valid_a  = 1'b0;
    valid_b  = 1'b0;
    row      = 2'd0;
    col      = 2'd0;
`ifdef BOARD_UNDO_EN
    undo_a   = 1'b0;
    undo_b   = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",  32'(rdy_a),   32'd0);
    check("rst_board",  32'(board_a), 32'd0);
    check("rst_turn",   32'(turn_a),  32'd1);
    check("rst_game",   32'(game_a),  32'd0);
    check("rst_done",   32'(done_a),  32'd0);
    check("rst_status", 32'(st_a),    32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("ready_pre_edge", 32'(rdy_a), 32'd0);
    @(posedge clock); #1;
    check("ready_first_edge", 32'(rdy_a), 32'd1);

    // 3x4: out-of-range row, then a legal move with L=7
    play(1'b1, 3, 0);
    check("b_range_status", r_st, 2);
    check("b_range_lat",    r_lat, 1);
    check("b_range_board",  32'(r_board), 32'd0);
    check("b_range_turn",   r_turn, 1);
    play(1'b1, 1, 3);
    check("b_legal_status", r_st, 0);
    check("b_legal_lat",    r_lat, 9);
    check("b_legal_board",  32'(r_board1), 32'h004000);
    check("b_legal_turn",   r_turn, 2);

    // 3x3: X wins along row 0
    play(1'b0, 0, 0);
    check("a_first_lat",   r_lat, 10);
    check("a_first_write", 32'(r_board1), 32'h1);
    check("a_first_turn",  r_turn, 2);
    play(1'b0, 1, 0);
    play(1'b0, 0, 1);
    play(1'b0, 1, 1);
    check("a_prewin_game", r_game, 0);
    play(1'b0, 0, 2);
    check("xwin_status", r_st, 0);
    check("xwin_lat",    r_lat, 10);
    check("xwin_game",   r_game, 1);
    check("xwin_board",  32'(r_board), 32'h295);
    check("xwin_turn",   r_turn, 2);
    play(1'b0, 2, 2);
    check("over_status", r_st, 3);
    check("over_lat",    r_lat, 1);
    check("over_board",  32'(r_board), 32'h295);

`ifdef BOARD_UNDO_EN
    do_undo();
    check("undo_status", r_st, 0);
    check("undo_lat",    r_lat, 1);
    check("undo_board",  32'(r_board), 32'h285);
    check("undo_game",   r_game, 0);
    check("undo_turn",   r_turn, 1);
    do_undo();
    check("undo2_status", r_st, 3);
    check("undo2_board",  32'(r_board), 32'h285);
    check("undo2_turn",   r_turn, 1);
`endif

    pulse_new_game();
    check("ng_board", 32'(board_a), 32'd0);
    check("ng_turn",  32'(turn_a),  32'd1);
    check("ng_game",  32'(game_a),  32'd0);

    // same cell twice
    play(1'b0, 0, 0);
    play(1'b0, 0, 0);
    check("occ_status", r_st, 1);
    check("occ_lat",    r_lat, 1);
    check("occ_board",  32'(r_board), 32'h1);
    check("occ_turn",   r_turn, 2);
    play(1'b0, 3, 1);
    check("a_range_status", r_st, 2);
    check("a_range_lat",    r_lat, 1);

    // new_game while the scan is running
    pulse_new_game();
    wait_ready(1'b0);
    row = 2'd1;
    col = 2'd1;
    valid_a = 1'b1;
    @(posedge clock); #1;
    valid_a = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    check("abort_board", 32'(board_a), 32'd0);
    check("abort_turn",  32'(turn_a),  32'd1);
    check("abort_ready", 32'(rdy_a),   32'd1);
    n = 0;
    repeat (15) begin
      if (done_a) n++;
      @(posedge clock); #1;
    end
    check("abort_no_done", n, 0);

    // O wins on the anti diagonal (the last line scanned)
    for (int i = 0; i < 6; i++) play(1'b0, dr_owin[i], dc_owin[i]);
    check("owin_status", r_st, 0);
    check("owin_lat",    r_lat, 10);
    check("owin_game",   r_game, 2);

    // full board without a line
    pulse_new_game();
    for (int i = 0; i < 9; i++) begin
      play(1'b0, dr_draw[i], dc_draw[i]);
      if (i == 7) check("draw_pre_game", r_game, 0);
    end
    check("draw_status", r_st, 0);
    check("draw_game",   r_game, 3);
    check("draw_turn",   r_turn, 2);
    play(1'b0, 0, 0);
    check("draw_over_status", r_st, 3);
    check("draw_over_game",   r_game, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
